slc3_mem_bridge: RTL and testbench

Memory-side stage directly downstream of the SLC-3 control unit. It consumes the control unit's mem_mem_ena/mem_wr_ena strobes, plus MAR and MDR from the datapath, and sequences a synchronous BRAM with an output register. It also decodes memory-mapped I/O, with switches readable and a hex display register writable, at the top of the address space. It returns mem_rdata in time for the control unit to load MDR on the last cycle of its fixed wait-state sequence.

---
 rtl/slc3_mem_bridge.sv | 148 ++++++++++++++
 tb/tb_slc3_mem_bridge.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/slc3_mem_bridge.sv
// Memory-side bridge for the SLC-3: sequences a registered-output BRAM and decodes switch/hex MMIO.
// Optional `define MMIO_LED_EN adds an LED register at 16'hFFFE.
module slc3_mem_bridge #(
  parameter int unsigned BRAM_AW  = 16,
  parameter int unsigned READ_LAT = 2,
  parameter logic [15:0] IO_ADDR  = 16'hFFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_mem_ena,
  input  logic               mem_wr_ena,
  input  logic [15:0]        mem_addr,
  input  logic [15:0]        mem_wdata,
  output logic [15:0]        mem_rdata,
  input  logic [15:0]        sw_i,
  output logic [15:0]        hex_o,
  output logic [15:0]        led_o,
  output logic [BRAM_AW-1:0] bram_addr,
  output logic               bram_en,
  output logic               bram_we,
  output logic [15:0]        bram_wdata,
  input  logic [15:0]        bram_rdata,
  output logic               busy_o,
  output logic               rdata_valid_o
);

  localparam int unsigned   CW       = $clog2(READ_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(READ_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 arm_q;
  logic [BRAM_AW-1:0]   addr_q;
  logic                 io_sel_q;
  logic                 wr_q;
  logic [15:0]          io_rdata_q;
  logic [15:0]          hex_q;
  logic [15:0]          sw_meta_q, sw_sync_q;

  logic                 start;
  logic                 io_now;
  logic                 led_now;
  logic                 mmio_now;
  logic [15:0]          io_src;

`ifdef MMIO_LED_EN
  logic [15:0] led_q;

  always_comb begin
    led_now = (mem_addr == 16'hFFFE);
    io_src  = led_now ? led_q : sw_sync_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= '0;
    end else if (start && led_now && mem_wr_ena) begin
      led_q <= mem_wdata;
    end
  end

  assign led_o = led_q;
`else
  always_comb begin
    led_now = 1'b0;
    io_src  = sw_sync_q;
  end

  assign led_o = '0;
`endif

  // arm_q demands an ena-low cycle before any access, so a strobe held across reset cannot re-trigger.
  always_comb begin
    io_now   = (mem_addr == IO_ADDR);
    mmio_now = io_now | led_now;
    start    = (state_q == IDLE) && mem_mem_ena && arm_q;
  end

  // HOLD begins in access cycle READ_LAT+1, so ACCESS spans cycles 2..READ_LAT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (READ_LAT <= 1) begin
            state_d = HOLD;
          end else begin
            state_d = ACCESS;
            cnt_d   = CW'(1);
          end
        end
      end
      ACCESS: begin
        if (!mem_mem_ena)          state_d = IDLE;
        else if (cnt_q == CNT_LAST) state_d = HOLD;
        else                       cnt_d   = cnt_q + CW'(1);
      end
      HOLD: begin
        if (!mem_mem_ena) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      arm_q      <= 1'b0;
      addr_q     <= '0;
      io_sel_q   <= 1'b0;
      wr_q       <= 1'b0;
      io_rdata_q <= '0;
      hex_q      <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      arm_q     <= ~mem_mem_ena;
      sw_meta_q <= sw_i;
      sw_sync_q <= sw_meta_q;
      if (start) begin
        addr_q   <= mem_addr[BRAM_AW-1:0];
        io_sel_q <= mmio_now;
        wr_q     <= mem_wr_ena;
        if (io_now && mem_wr_ena)    hex_q      <= mem_wdata;
        if (mmio_now && !mem_wr_ena) io_rdata_q <= io_src;
      end
    end
  end

  always_comb begin
    bram_we       = start && mem_wr_ena && !mmio_now;
    bram_en       = start ? !mmio_now
                          : ((state_q != IDLE) && mem_mem_ena && !io_sel_q);
    bram_addr     = start ? mem_addr[BRAM_AW-1:0] : addr_q;
    bram_wdata    = mem_wdata;
    mem_rdata     = io_sel_q ? io_rdata_q : bram_rdata;
    busy_o        = (state_q != IDLE);
    rdata_valid_o = (state_q == HOLD) && !wr_q;
    hex_o         = hex_q;
  end

endmodule

// File: tb/tb_slc3_mem_bridge.sv
// Directed plus randomized bench for slc3_mem_bridge against a transaction-level memory/MMIO model.
module tb_slc3_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_mem_ena, mem_wr_ena;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] sw_i, hex_o, led_o;
  logic [15:0] bram_addr;
  logic        bram_en, bram_we;
  logic [15:0] bram_wdata, bram_rdata;
  logic        busy_o, rdata_valid_o;

  int errors = 0;
  int checks = 0;

  // Transaction-level reference: what each location / register should hold.
  logic [15:0] exp_mem [int];
  logic [15:0] exp_hex = '0;
  logic [15:0] exp_led = '0;
  logic [15:0] cur_sw  = '0;

  always #5 clk = ~clk;

  slc3_mem_bridge #(.BRAM_AW(16), .READ_LAT(2), .IO_ADDR(16'hFFFF)) dut (
    .clk(clk), .reset(reset),
    .mem_mem_ena(mem_mem_ena), .mem_wr_ena(mem_wr_ena),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .sw_i(sw_i), .hex_o(hex_o), .led_o(led_o),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
    .busy_o(busy_o), .rdata_valid_o(rdata_valid_o)
  );

  // Synchronous BRAM with an output register: two edges from address to data.
  logic [15:0] ram [0:65535];
  logic [15:0] rd_stage;
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) ram[bram_addr] <= bram_wdata;
      rd_stage <= ram[bram_addr];
    end
    bram_rdata <= rd_stage;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    mem_mem_ena = 1'b0;
    mem_wr_ena  = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // One strobe of n cycles, checked cycle by cycle against the access rules.
  task automatic acc(input logic [15:0] a, input bit wr, input logic [15:0] d, input int n);
    int          we_cnt = 0;
    int          en_cnt = 0;
    bit          is_io  = (a == 16'hFFFF);
    bit          is_led;
    bit          mmio;
    bit          known;
    logic [15:0] exp_rd;
`ifdef MMIO_LED_EN
    is_led = (a == 16'hFFFE);
`else
    is_led = 1'b0;
`endif
    mmio   = is_io | is_led;
    known  = mmio || exp_mem.exists(int'(a));
    exp_rd = is_io ? cur_sw : is_led ? exp_led : (known ? exp_mem[int'(a)] : 16'h0);
    for (int c = 1; c <= n; c++) begin
      mem_mem_ena = 1'b1;
      mem_wr_ena  = wr;
      mem_addr    = a;
      mem_wdata   = d;
      @(negedge clk);
      we_cnt += int'(bram_we);
      en_cnt += int'(bram_en);
      check("busy", 16'(busy_o), 16'(c >= 2));
      check("rdata_valid", 16'(rdata_valid_o), 16'(!wr && c >= 3));
      if (!wr && c == 3 && known) check("mem_rdata", mem_rdata, exp_rd);
      tick();
    end
    check("we_pulses", 16'(we_cnt), 16'(wr && !mmio));
    check("bram_en_seen", 16'(en_cnt != 0), 16'(!mmio));
    if (wr) begin
      if (is_io)       exp_hex = d;
      else if (is_led) exp_led = d;
      else             exp_mem[int'(a)] = d;
    end
    mem_mem_ena = 1'b0;
    mem_wr_ena  = 1'b0;
    tick();
    @(negedge clk);
    check("busy_after", 16'(busy_o), 16'h0);
    check("hex_o", hex_o, exp_hex);
    check("led_o", led_o, exp_led);
    tick();
  endtask

  task automatic set_sw(input logic [15:0] v);
    sw_i   = v;
    cur_sw = v;
    idle(3);
  endtask

  initial begin
    logic [15:0] pool [6];
    logic [15:0] a;
    int          sel;

    reset       = 1'b1;
    mem_mem_ena = 1'b0;
    mem_wr_ena  = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    sw_i        = '0;
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_hex", hex_o, 16'h0);
    check("rst_led", led_o, 16'h0);
    check("rst_busy", 16'(busy_o), 16'h0);
    check("rst_valid", 16'(rdata_valid_o), 16'h0);
    check("rst_we", 16'(bram_we), 16'h0);
    check("rst_en", 16'(bram_en), 16'h0);
    tick();
    idle(1);

    acc(16'h0010, 1'b1, 16'h1234, 3);
    acc(16'h0010, 1'b0, 16'h0000, 3);
    acc(16'hFFFF, 1'b1, 16'h00AB, 3);
    set_sw(16'h5A5A);
    acc(16'hFFFF, 1'b0, 16'h0000, 3);
    acc(16'h0020, 1'b1, 16'hBEEF, 6);
    acc(16'h0020, 1'b0, 16'h0000, 6);
    acc(16'h0010, 1'b0, 16'h0000, 2);

    // Reset in cycle 2 of an I/O write: the cycle-1 hex update is visible, then cleared.
    mem_mem_ena = 1'b1;
    mem_wr_ena  = 1'b1;
    mem_addr    = 16'hFFFF;
    mem_wdata   = 16'h0077;
    tick();
    @(negedge clk);
    check("hex_before_rst", hex_o, 16'h0077);
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    mem_mem_ena = 1'b0;
    mem_wr_ena  = 1'b0;
    exp_hex     = '0;
    exp_led     = '0;
    @(negedge clk);
    check("hex_after_rst", hex_o, 16'h0);
    check("busy_after_rst", 16'(busy_o), 16'h0);
    check("valid_after_rst", 16'(rdata_valid_o), 16'h0);
    tick();
    set_sw(16'h5A5A);

    acc(16'hFFFE, 1'b1, 16'h00FF, 3);
    acc(16'hFFFE, 1'b0, 16'h0000, 3);

    for (int i = 0; i < 6; i++) begin
      pool[i] = 16'($urandom_range(16'h0100, 16'hFF00));
      acc(pool[i], 1'b1, 16'($urandom), 3);
    end
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) set_sw(16'($urandom));
      sel = $urandom_range(0, 7);
      a   = (sel == 6) ? 16'hFFFF : (sel == 7) ? 16'hFFFE : pool[sel];
      acc(a, 1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(1, 5));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
